// File: rtl/sar_pkg.sv
// sar_pkg: shared constants, state encoding and helpers for the SAR controller.
// Used by: sar_bit_pointer, sar_controller.
// Optional feature macro referenced by the controller: SAR_EARLY_EXIT_EN.
package sar_pkg;

  // Default trial/result width; must match the comparator operand width.
  localparam int SAR_WIDTH = 4;

  // FSM state encoding (plain constants so older tools can consume them).
  typedef logic [1:0] sar_state_t;
  localparam sar_state_t ST_IDLE = 2'd0;
  localparam sar_state_t ST_CONV = 2'd1;
  localparam sar_state_t ST_DONE = 2'd2;

  // First trial of every conversion: MSB set, all lower bits clear.
  localparam logic [SAR_WIDTH-1:0] SAR_TRIAL_INIT = {1'b1, {(SAR_WIDTH-1){1'b0}}};

  // True when exactly one of the three comparator outputs is asserted.
  function automatic logic is_one_hot3(input logic a, input logic b, input logic c);
    return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
  endfunction

endpackage

// File: rtl/sar_bit_pointer.sv
// sar_bit_pointer: one-hot bit pointer for the SAR, loads at the MSB and shifts toward the LSB.
// Latency: pointer updates on the clock edge after load/shift; last is combinational on the pointer.
// Backpressure: none; the owner only shifts while bits remain, so the pointer never underflows.
// Ports:
//   clk, rst : clock and synchronous active-high reset (pointer cleared)
//   load     : place the pointer on bit WIDTH-1 (takes priority over shift)
//   shift    : move the pointer one bit toward the LSB
//   ptr      : one-hot pointer, bit i set means bit i is being decided
//   last     : pointer is on bit 0
module sar_bit_pointer
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  output logic [WIDTH-1:0] ptr,
  output logic             last
);

  localparam logic [WIDTH-1:0] PTR_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= PTR_MSB;
    end else if (shift) begin
      ptr <= ptr >> 1;
    end
  end

  assign last = ptr[0];

endmodule

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation controller driving comparator B, one bit per clock, MSB first.
// Latency: start sampled at edge k -> CONV in cycles k+1..k+WIDTH, done pulse in cycle k+WIDTH+1.
// Backpressure: none; start is only honoured in IDLE, so a new conversion begins one cycle after done at the earliest.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset (aborts any conversion)
//   start                    : conversion request, sampled in IDLE only
//   cmp_gt, cmp_eq, cmp_lt   : comparator decision for A versus trial, combinational in the same cycle
//   trial                    : current trial code, drives comparator B
//   result                   : last converged code, held until the next conversion completes
//   busy                     : high in every CONV cycle
//   done                     : one-cycle pulse in the cycle after result is written
//   err                      : sticky flag, set when the comparator outputs are not one-hot during CONV
// Optional: define SAR_EARLY_EXIT_EN to end a conversion as soon as the comparator reports equality.
module sar_controller
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       state;
  logic [WIDTH-1:0] ptr;
  logic             ptr_last;
  logic             in_conv;
  logic             ptr_load;
  logic             ptr_shift;
  logic             cmp_valid;
  logic             early_exit;
  logic [WIDTH-1:0] decided;

  assign in_conv   = (state == ST_CONV);
  assign ptr_load  = (state == ST_IDLE) && start;
  assign cmp_valid = is_one_hot3(cmp_gt, cmp_eq, cmp_lt);

  // Only cmp_lt clears the bit under test. This also covers a malformed
  // comparator response: whatever else is asserted, the bit is kept unless
  // cmp_lt is high.
  assign decided = trial & ~(ptr & {WIDTH{cmp_lt}});

`ifdef SAR_EARLY_EXIT_EN
  // A clean equality means the current trial already is the answer; the
  // lower bits are still zero, so trial can be taken as the result as-is.
  assign early_exit = in_conv && cmp_valid && cmp_eq;
`else
  assign early_exit = 1'b0;
`endif

  // Advance only while lower bits remain, so the pointer stops on bit 0.
  assign ptr_shift = in_conv && !ptr_last && !early_exit;

  sar_bit_pointer #(
    .WIDTH (WIDTH)
  ) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .load  (ptr_load),
    .shift (ptr_shift),
    .ptr   (ptr),
    .last  (ptr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      trial  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CONV;
            trial <= TRIAL_INIT;
          end else begin
            trial <= '0;
          end
        end

        ST_CONV: begin
          if (!cmp_valid) begin
            err <= 1'b1;
          end
          if (early_exit) begin
            result <= trial;
            state  <= ST_DONE;
          end else if (ptr_last) begin
            result <= decided;
            trial  <= decided;
            state  <= ST_DONE;
          end else begin
            // Apply this bit's decision and raise the next lower bit as the
            // new trial in the same edge.
            trial <= decided | (ptr >> 1);
          end
        end

        ST_DONE: begin
          trial <= '0;
          state <= ST_IDLE;
        end

        default: begin
          trial <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_CONV);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: directed bench for sar_controller with a bench-side comparator and a
// plan-based reference model checked every cycle, plus hand-computed literal expectations.
module tb_sar_controller;
  import sar_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cmp_gt, cmp_eq, cmp_lt;
  logic [W-1:0] trial, result;
  logic         busy, done, err;

  logic [W-1:0] a_val;      // unknown value on comparator A
  logic         force_now;  // drive an illegal gt+lt response this cycle

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  // Comparator: combinational on trial, with an override for the protocol check.
  assign cmp_gt = force_now ? 1'b1 : (a_val > trial);
  assign cmp_eq = force_now ? 1'b0 : (a_val == trial);
  assign cmp_lt = force_now ? 1'b1 : (a_val < trial);

  sar_controller #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .trial  (trial),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A conversion of value v is a binary search: step s tries the bits of v
  // above position W-1-s with that position set. A forced "less" at a
  // position where v has a 1 permanently drops that bit, after which every
  // lower trial is below v and all lower bits are kept: the search then
  // behaves as if converting m_eff.
  int m_phase  = 0;  // 0 idle, 1 converting, 2 done pulse
  int m_step   = 0;
  int m_eff    = 0;
  int m_result = 0;
  bit m_err    = 0;
  int m_t, m_bp;

  function automatic int trial_of(input int eff, input int step);
    int bp;
    bp = W - 1 - step;
    return ((eff >> (bp + 1)) << (bp + 1)) | (1 << bp);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = 0;
      m_result = 0;
      m_err    = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_step  = 0;
          m_eff   = int'(a_val);
        end
        1: begin
          m_t  = trial_of(m_eff, m_step);
          m_bp = W - 1 - m_step;
          if (force_now) begin
            m_err = 1;
            if (((m_eff >> m_bp) & 1) == 1)
              m_eff = ((m_eff >> (m_bp + 1)) << (m_bp + 1)) | ((1 << m_bp) - 1);
          end
`ifdef SAR_EARLY_EXIT_EN
          if (!force_now && m_t == int'(a_val)) begin
            m_result = m_t;
            m_phase  = 2;
          end else
`endif
          if (m_step == W - 1) begin
            m_result = m_eff;
            m_phase  = 2;
          end else begin
            m_step = m_step + 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_phase == 1) ? 1 : 0);
      chk("done", done, (m_phase == 2) ? 1 : 0);
      chk("err", err, m_err);
      chk("result", result, m_result);
      if (m_phase == 0) chk("trial_idle", trial, 0);
      if (m_phase == 1) chk("trial_conv", trial, trial_of(m_eff, m_step));
    end
  end

  // ---------------- stimulus ----------------
  int tr_log[$];
  int lat, nbusy;

  // Call and return on a negedge in an IDLE cycle. force_at is the CONV
  // step (0-based) at which the comparator is forced, -1 for none.
  task automatic do_conv(input int a, input int force_at);
    int cyc;
    bit seen;
    a_val = W'(a);
    start = 1'b1;
    tr_log.delete();
    nbusy = 0;
    lat   = -1;
    seen  = 0;
    @(posedge clk);                 // edge k samples start
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 20 && !seen) begin
      force_now = (cyc == force_at + 1);
      if (busy) begin
        tr_log.push_back(int'(trial));
        nbusy++;
      end
      if (done) begin
        lat  = cyc;
        seen = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    force_now = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);                 // back in IDLE
  endtask

  initial begin
    int ndone, last_done, gap_bad;
    bit prev_busy, seen_done;

    rst = 1'b1; start = 1'b0; a_val = '0; force_now = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trial", trial, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);

    // A=9: 1000, 1100, 1010, 1001
    do_conv(9, -1);
    chk("a9_ntrials", tr_log.size(), 4);
    if (tr_log.size() == 4) begin
      chk("a9_trial0", tr_log[0], int'(SAR_TRIAL_INIT));
      chk("a9_trial1", tr_log[1], 12);
      chk("a9_trial2", tr_log[2], 10);
      chk("a9_trial3", tr_log[3], 9);
    end
    chk("a9_result", result, 9);
    chk("a9_latency", lat, 5);
    chk("a9_busy_cycles", nbusy, 4);

    // A=0: 1000, 0100, 0010, 0001 -> 0000
    do_conv(0, -1);
    chk("a0_ntrials", tr_log.size(), 4);
    if (tr_log.size() == 4) begin
      chk("a0_trial1", tr_log[1], 4);
      chk("a0_trial2", tr_log[2], 2);
      chk("a0_trial3", tr_log[3], 1);
    end
    chk("a0_result", result, 0);

    // A=15: 1000, 1100, 1110, 1111 -> 1111
    do_conv(15, -1);
    if (tr_log.size() == 4) begin
      chk("a15_trial2", tr_log[2], 14);
      chk("a15_trial3", tr_log[3], 15);
    end
    chk("a15_result", result, 15);

    // Reset on the 2nd CONV cycle aborts without a done pulse.
    a_val = 4'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_trial", trial, 0);
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);
    do_conv(9, -1);
    chk("after_abort_result", result, 9);

    // start held high, A=5: back-to-back conversions, one IDLE cycle between.
    a_val = 4'd5;
    start = 1'b1;
    ndone = 0; last_done = -100; gap_bad = 0; prev_busy = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        last_done = c;
        chk("b2b_result", result, 5);
      end
      if (busy && !prev_busy && last_done > 0 && (c - last_done) != 2) gap_bad++;
      prev_busy = busy;
    end
    start = 1'b0;
    chk("b2b_ndone", ndone, 5);
    chk("b2b_gap", gap_bad, 0);
    repeat (8) @(negedge clk);

    // Illegal comparator response on the 2nd CONV cycle, A=15:
    // 1100 cleared -> 1010, 1011; err sticks until reset.
    do_conv(15, 1);
    chk("err_result", result, 11);
    chk("err_set", err, 1);
    do_conv(5, -1);
    chk("err_sticky_result", result, 5);
    chk("err_sticky", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", err, 0);
    @(negedge clk);

    // A=8: first trial is equal.
    do_conv(8, -1);
    chk("a8_result", result, 8);
`ifdef SAR_EARLY_EXIT_EN
    chk("a8_latency", lat, 2);
`else
    chk("a8_latency", lat, 5);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
